datapath_memory_stage: RTL and testbench

//  MEM stage of the 5-stage RV32I pipeline: consumes the EX/MEM register outputs, drives a ready/req data-memory bus,

---
 rtl/datapath_memory_stage.sv | 155 +++++++++++++++
 tb/tb_datapath_memory_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath_memory_stage.sv
// MEM stage of the RV32I pipeline: data-memory bus master with store lane steering, load extraction,
// wait/timeout handling, the MEM/WB pipeline register and the writeback result mux.
module datapath_memory_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        StallM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ResultW,
  output logic        MisalignW,
  output logic        BusErrW,
  output logic        dbg_state
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;

  logic        is_load, access, size_b, size_h, size_w, unsigned_ld;
  logic        misalign_m, req_ok, wait_max, abort;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Stores take priority over a load encoding on the same instruction.
  assign is_load     = (ResultSrcM == 2'b01) & ~MemWriteM;
  assign access      = MemWriteM | (ResultSrcM == 2'b01);
  assign size_b      = (funct3M == 3'b000) | (funct3M == 3'b100);
  assign size_h      = (funct3M == 3'b001) | (funct3M == 3'b101);
  assign size_w      = ~size_b & ~size_h;
  assign unsigned_ld = funct3M[2] & ~funct3M[1];

  assign misalign_m = access & ((size_h & ALUResultM[0]) | (size_w & (|ALUResultM[1:0])));
  assign req_ok     = access & ~misalign_m;

  // Handshake: a request is accepted in the cycle where mem_req and mem_ready are both high;
  // until then the pipeline is stalled so every bus output stays constant.
  assign mem_req  = ~reset & ((state == WAIT) | req_ok);
  assign mem_we   = mem_req & MemWriteM;
  assign mem_addr = {ALUResultM[31:2], 2'b00};

  assign wait_max = (wait_cnt == CNT_MAX);
  assign abort    = mem_req & ~mem_ready & wait_max;
  assign StallM   = mem_req & ~mem_ready & ~wait_max;

  assign dbg_state = (state == WAIT);

  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = WriteDataM;
    if (size_b) begin
      mem_be    = 4'b0001 << ALUResultM[1:0];
      mem_wdata = {4{WriteDataM[7:0]}};
    end else if (size_h) begin
      mem_be    = 4'b0011 << {ALUResultM[1], 1'b0};
      mem_wdata = {2{WriteDataM[15:0]}};
    end
  end

  always_comb begin
    byte_sel  = 8'(mem_rdata >> {ALUResultM[1:0], 3'b000});
    half_sel  = ALUResultM[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    if (size_b)
      load_data = unsigned_ld ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    else if (size_h)
      load_data = unsigned_ld ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mem_req & ~mem_ready & ~abort) state_next = WAIT;
      WAIT: if (~mem_req | mem_ready | abort)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (mem_req & ~mem_ready & ~abort) ? wait_cnt + 1'b1 : '0;
    end
  end

  // MEM/WB: a stall, misaligned access or aborted access leaves a bubble in WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else if (StallM | abort | misalign_m) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      MisalignW  <= misalign_m;
      BusErrW    <= abort;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= is_load ? load_data : 32'h0;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM & ~MemWriteM;
      ResultSrcW <= ResultSrcM;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end
  end

  always_comb begin
    case (ResultSrcW)
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_datapath_memory_stage.sv
// Directed bench for datapath_memory_stage: inputs change on the falling edge, outputs are checked
// just after it (combinational) or on the next falling edge (registered).
module tb_datapath_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        StallM;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic        MisalignW, BusErrW, dbg_state;

  int checks = 0;
  int errors = 0;
  int req_cnt, stall_cnt;

  datapath_memory_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .StallM(StallM),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ResultW(ResultW),
    .MisalignW(MisalignW), .BusErrW(BusErrW), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic regw, input logic [1:0] rsrc,
                       input logic memw, input logic [2:0] f3);
    ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RdM = rd;
    RegWriteM = regw; ResultSrcM = rsrc; MemWriteM = memw; funct3M = f3;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 3'b000);
  endtask

  // zero-wait load with hand-computed result
  task automatic load_now(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [31:0] exp);
    @(negedge clk);
    drive(a, 32'h0, 32'h0, 5'd9, 1'b1, 2'b01, 1'b0, f3);
    mem_rdata = rdata; mem_ready = 1'b1;
    #1 check({tag, "_stall"}, StallM, 0);
    @(negedge clk);
    check({tag, "_data"}, ReadDataW, exp);
    check({tag, "_result"}, ResultW, exp);
  endtask

  task automatic store_now(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f3, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
    @(negedge clk);
    drive(a, d, 32'h0, 5'd3, 1'b1, 2'b00, 1'b1, f3);
    mem_ready = 1'b1;
    #1;
    check({tag, "_req"}, mem_req, 1);
    check({tag, "_we"}, mem_we, 1);
    check({tag, "_be"}, mem_be, exp_be);
    check({tag, "_wdata"}, mem_wdata, exp_wdata);
    check({tag, "_addr"}, mem_addr, exp_addr);
    check({tag, "_stall"}, StallM, 0);
    @(negedge clk);
    check({tag, "_regwrite_w"}, RegWriteW, 0);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0;
    drive(32'h100, 32'h0, 32'h0, 5'd1, 1'b1, 2'b01, 1'b0, 3'b010);
    #1 check("reset_req", mem_req, 0);
    check("reset_stall", StallM, 0);
    @(posedge clk); @(negedge clk);
    check("reset_regwrite_w", RegWriteW, 0);
    check("reset_result_w", ResultW, 0);
    check("reset_state", dbg_state, 0);
    reset = 1'b0; nop();

    // SW, zero wait
    store_now("sw", 32'h100, 32'hDEADBEEF, 3'b010, 4'b1111, 32'hDEADBEEF, 32'h100);
    check("sw_alu_w", ALUResultW, 32'h100);

    // LB with three wait cycles
    @(negedge clk);
    drive(32'h103, 32'h0, 32'h0, 5'd5, 1'b1, 2'b01, 1'b0, 3'b000);
    mem_ready = 1'b0; mem_rdata = 32'h80123456;
    for (int i = 0; i < 3; i++) begin
      #1 check("lb_wait_stall", StallM, 1);
      check("lb_wait_req", mem_req, 1);
      @(negedge clk);
      check("lb_wait_bubble", RegWriteW, 0);
      check("lb_wait_state", dbg_state, 1);
    end
    mem_ready = 1'b1;
    #1 check("lb_done_stall", StallM, 0);
    @(negedge clk);
    check("lb_data", ReadDataW, 32'hFFFFFF80);
    check("lb_rd", RdW, 5);
    check("lb_result", ResultW, 32'hFFFFFF80);
    check("lb_regwrite", RegWriteW, 1);
    check("lb_state", dbg_state, 0);

    load_now("lbu", 32'h103, 3'b100, 32'h80123456, 32'h00000080);
    load_now("lb0", 32'h100, 3'b000, 32'h80123456, 32'h00000056);
    load_now("lh", 32'h102, 3'b001, 32'h80123456, 32'hFFFF8012);
    load_now("lhu", 32'h102, 3'b101, 32'h80123456, 32'h00008012);
    load_now("lh0", 32'h100, 3'b001, 32'h8012F456, 32'hFFFFF456);
    load_now("lw", 32'h100, 3'b010, 32'h80123456, 32'h80123456);

    store_now("sh", 32'h102, 32'h1234ABCD, 3'b001, 4'b1100, 32'hABCDABCD, 32'h100);
    store_now("sb", 32'h101, 32'h000000EF, 3'b000, 4'b0010, 32'hEFEFEFEF, 32'h100);

    // misaligned LW
    @(negedge clk);
    drive(32'h101, 32'h0, 32'h0, 5'd7, 1'b1, 2'b01, 1'b0, 3'b010);
    mem_ready = 1'b0;
    #1 check("mis_req", mem_req, 0);
    check("mis_stall", StallM, 0);
    @(negedge clk);
    check("mis_flag", MisalignW, 1);
    check("mis_regwrite", RegWriteW, 0);
    nop();
    @(negedge clk);
    check("mis_pulse", MisalignW, 0);

    // timeout abort
    drive(32'h200, 32'h0, 32'h0, 5'd8, 1'b1, 2'b01, 1'b0, 3'b010);
    mem_ready = 1'b0; req_cnt = 0; stall_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      req_cnt += int'(mem_req);
      stall_cnt += int'(StallM);
      @(negedge clk);
      if (k < 15) check("to_no_buserr", BusErrW, 0);
    end
    check("to_req_cycles", req_cnt, 16);
    check("to_stall_cycles", stall_cnt, 15);
    check("to_buserr", BusErrW, 1);
    check("to_regwrite", RegWriteW, 0);
    check("to_state", dbg_state, 0);
    nop();
    @(negedge clk);
    check("to_pulse", BusErrW, 0);

    // reset during the second WAIT cycle
    drive(32'h300, 32'h0, 32'h0, 5'd4, 1'b1, 2'b01, 1'b0, 3'b010);
    @(negedge clk); @(negedge clk);
    check("rst_in_wait", dbg_state, 1);
    reset = 1'b1;
    #1 check("rst_req", mem_req, 0);
    check("rst_stall", StallM, 0);
    @(negedge clk);
    reset = 1'b0;
    check("rst_buserr", BusErrW, 0);
    check("rst_state", dbg_state, 0);
    check("rst_rd_w", RdW, 0);
    drive(32'h440, 32'h0, 32'h444, 5'd1, 1'b1, 2'b10, 1'b0, 3'b000);
    #1 check("jal_req", mem_req, 0);
    @(negedge clk);
    check("jal_result", ResultW, 32'h444);
    check("jal_regwrite", RegWriteW, 1);
    check("jal_rd", RdW, 1);

    // ALU pass-through and the unused result select
    drive(32'h1234, 32'h0, 32'h88, 5'd2, 1'b1, 2'b00, 1'b0, 3'b000);
    @(negedge clk);
    check("alu_result", ResultW, 32'h1234);
    drive(32'h1234, 32'h0, 32'h88, 5'd2, 1'b1, 2'b11, 1'b0, 3'b000);
    @(negedge clk);
    check("src11_result", ResultW, 32'h0);
    nop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
